fetch_ctrl: RTL

- Sequencer for the 16-bit instruction fetch stage.
- Owns the PC register, issues req/ack transactions to instruction memory and loads the IF/ID register (InstrD, PCPlus2D, ValidD).
- Applies decode stalls and execute-stage branch redirects, and discards responses that belong to squashed fetches.
- Sits between the hazard unit / execute stage and the instruction memory port.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_if.sv | 16 +
 rtl/imem_wait_counter.sv | 32 +++
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the 16-bit instruction fetch sequencer.
package fetch_pkg;

  localparam int XLEN_DEF = 16;
  localparam logic [XLEN_DEF-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory req/ack port; the fetch controller is the master.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/imem_wait_counter.sv
// Saturating count of unanswered request cycles; pulses o_timeout on the
// cycle the count reaches MAX_WAIT.
module imem_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en && (r_cnt != CW'(MAX_WAIT))) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_timeout = i_en && !i_clr && (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs imem req/ack, loads IF/ID and
// squashes responses that belong to redirected fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_if.master         imem,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCPlus2D,
  output logic            ValidD,
  output logic            fetch_err
);

  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pcf, w_pcf_nxt;
  logic [XLEN-1:0] r_req_addr, w_req_addr_nxt;
  logic [XLEN-1:0] r_instr_d, w_instr_nxt;
  logic [XLEN-1:0] r_pcplus2_d, w_pcplus2_nxt;
  logic            r_valid_d, w_valid_nxt;
  logic [XLEN-1:0] r_hold, w_hold_nxt;
  logic            r_fetch_err;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_addr_plus2;
  logic            w_req;
  logic            w_timeout;

  assign w_target     = PCTargetE & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign w_addr_plus2 = r_req_addr + XLEN'(2);
  assign w_req        = (r_state == REQ) || (r_state == KILL);

  imem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_req && imem.imem_ack),
    .i_en      (w_req && !imem.imem_ack),
    .o_timeout (w_timeout)
  );

  // Next-state and next-register values; flush outranks stall outranks advance
  always_comb begin
    w_state_nxt    = r_state;
    w_pcf_nxt      = r_pcf;
    w_req_addr_nxt = r_req_addr;
    w_instr_nxt    = r_instr_d;
    w_pcplus2_nxt  = r_pcplus2_d;
    w_valid_nxt    = r_valid_d;
    w_hold_nxt     = r_hold;
    case (r_state)
      IDLE: begin
        w_req_addr_nxt = r_pcf;
        w_state_nxt    = REQ;
      end
      REQ: begin
        if (imem.imem_ack) begin
          if (PCSrcE) begin
            w_pcf_nxt      = w_target;
            w_req_addr_nxt = w_target;
            w_valid_nxt    = 1'b0;
            w_instr_nxt    = NOP;
          end else if (StallD) begin
            w_hold_nxt  = imem.imem_rdata;
            w_pcf_nxt   = w_addr_plus2;
            w_state_nxt = HOLD;
          end else begin
            w_instr_nxt    = imem.imem_rdata;
            w_pcplus2_nxt  = w_addr_plus2;
            w_valid_nxt    = 1'b1;
            w_pcf_nxt      = w_addr_plus2;
            w_req_addr_nxt = w_addr_plus2;
          end
        end else begin
          if (PCSrcE) begin
            w_pcf_nxt   = w_target;
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP;
            w_state_nxt = KILL;
          end else if (!StallD) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP;
          end else begin
            w_valid_nxt = r_valid_d;
          end
        end
      end
      KILL: begin
        // The old address stays on the bus until its response drains
        if (PCSrcE) begin
          w_pcf_nxt = w_target;
        end else begin
          w_pcf_nxt = r_pcf;
        end
        if (imem.imem_ack) begin
          w_req_addr_nxt = PCSrcE ? w_target : r_pcf;
          w_state_nxt    = REQ;
        end else begin
          w_state_nxt = KILL;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          w_valid_nxt    = 1'b0;
          w_instr_nxt    = NOP;
          w_pcf_nxt      = w_target;
          w_req_addr_nxt = w_target;
          w_state_nxt    = REQ;
        end else if (!StallD) begin
          w_instr_nxt    = r_hold;
          w_pcplus2_nxt  = r_pcf;
          w_valid_nxt    = 1'b1;
          w_req_addr_nxt = r_pcf;
          w_state_nxt    = REQ;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pcf       <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_instr_d   <= NOP;
      r_pcplus2_d <= {XLEN{1'b0}};
      r_valid_d   <= 1'b0;
      r_hold      <= NOP;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pcf       <= w_pcf_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_instr_d   <= w_instr_nxt;
      r_pcplus2_d <= w_pcplus2_nxt;
      r_valid_d   <= w_valid_nxt;
      r_hold      <= w_hold_nxt;
      r_fetch_err <= r_fetch_err | w_timeout;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_req_addr;
  assign PCF            = r_pcf;
  assign InstrD         = r_instr_d;
  assign PCPlus2D       = r_pcplus2_d;
  assign ValidD         = r_valid_d;
  assign fetch_err      = r_fetch_err;

endmodule
